dds_bank: RTL

Time-multiplexed, parametrised multi-channel DDS oscillator. It holds CHANNELS independent phase accumulators and, on each sample tick, walks them one channel per clock. For each channel it emits one sample shaped by that channel's selected waveform: saw, reverse saw, triangle, square or PWM. It sits between the control/config path and the mixer, and generalises the single-channel DDS and its separate waveform transforms with per-channel mode, duty, phase offset and hard sync.

---
 rtl/dds_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dds_bank.sv
// dds_bank: time-multiplexed CHANNELS-way DDS oscillator with per-channel waveform, duty, offset and hard sync.
// A tick starts a pass that updates one channel per clock and registers its sample at the same edge.
module dds_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 7,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic [CHANNELS-1:0] sync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_chan_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [WIDTH-1:0]    cfg_data_i,
  output logic                out_valid_o,
  output logic [CW-1:0]       out_chan_o,
  output logic [WIDTH-1:0]    out_sample_o,
  output logic                overrun_o,
  input  logic                overrun_clr_i
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CW-1:0]       CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_RST = {1'b1, {(PWM_BITS-1){1'b0}}};

  state_t                state_q;
  logic [CW-1:0]         ch_q;
  logic                  out_valid_q;
  logic [CW-1:0]         out_chan_q;
  logic [WIDTH-1:0]      out_sample_q;
  logic                  overrun_q;
  logic [CHANNELS-1:0]   sync_pend_q;

  logic [WIDTH-1:0]      phase_q  [CHANNELS];
  logic [WIDTH-1:0]      freq_q   [CHANNELS];
  logic [WIDTH-1:0]      offset_q [CHANNELS];
  logic [2:0]            mode_q   [CHANNELS];
  logic [PWM_BITS-1:0]   duty_q   [CHANNELS];

  logic [CHANNELS-1:0]   sync_clr;
  logic [CHANNELS-1:0]   sync_pend_d;
  logic                  overrun_d;
  logic [WIDTH-1:0]      phase_d;
  logic [WIDTH-1:0]      out_phase;
  logic [WIDTH-1:0]      sample_d;

  function automatic logic [WIDTH-1:0] shape(input logic [2:0]          mode,
                                             input logic [WIDTH-1:0]    p,
                                             input logic [PWM_BITS-1:0] duty);
    logic [WIDTH-1:0] dbl;
    dbl = p << 1;
    case (mode)
      3'd0:    shape = p;
      3'd1:    shape = ~p;
      3'd2:    shape = p[WIDTH-1] ? ~dbl : dbl;
      3'd3:    shape = {WIDTH{~p[WIDTH-1]}};
      3'd4:    shape = {WIDTH{p[WIDTH-1 -: PWM_BITS] < duty}};
      default: shape = '0;
    endcase
  endfunction

  always_comb begin
    sync_clr = '0;
    if (state_q == S_RUN) sync_clr[ch_q] = 1'b1;
    // a sync arriving on the very edge that processes its channel stays pending for the next pass
    sync_pend_d = (sync_pend_q & ~sync_clr) | sync_i;
    overrun_d   = (tick_i && (state_q == S_RUN)) || (overrun_q && !overrun_clr_i);
    phase_d     = sync_pend_q[ch_q] ? '0 : phase_q[ch_q] + freq_q[ch_q];
    out_phase   = phase_d + offset_q[ch_q];
    sample_d    = shape(mode_q[ch_q], out_phase, duty_q[ch_q]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
      sync_pend_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i]  <= '0;
        freq_q[i]   <= '0;
        offset_q[i] <= '0;
        mode_q[i]   <= '0;
        duty_q[i]   <= DUTY_RST;
      end
    end else begin
      sync_pend_q <= sync_pend_d;
      overrun_q   <= overrun_d;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i) begin
            case (cfg_addr_i)
              2'd0:    freq_q[cfg_chan_i]   <= cfg_data_i;
              2'd1:    mode_q[cfg_chan_i]   <= cfg_data_i[2:0];
              2'd2:    duty_q[cfg_chan_i]   <= cfg_data_i[PWM_BITS-1:0];
              default: offset_q[cfg_chan_i] <= cfg_data_i;
            endcase
          end
          if (tick_i) begin
            state_q <= S_RUN;
            ch_q    <= '0;
          end
        end
        S_RUN: begin
          phase_q[ch_q] <= phase_d;
          out_valid_q   <= 1'b1;
          out_chan_q    <= ch_q;
          out_sample_q  <= sample_d;
          if (ch_q == CH_LAST) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
          end else begin
            ch_q <= ch_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ch_q    <= '0;
        end
      endcase
    end
  end

  assign cfg_ready_o  = (state_q == S_IDLE);
  assign out_valid_o  = out_valid_q;
  assign out_chan_o   = out_chan_q;
  assign out_sample_o = out_sample_q;
  assign overrun_o    = overrun_q;

endmodule
